cam_pixel_pack: RTL and testbench

CAM_PIXEL_PACK -- requirements
Module: cam_pixel_pack

---
 rtl/cam_pixel_pack.sv | 112 +++++++++++
 tb/tb_cam_pixel_pack.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_pixel_pack.sv
// Camera byte-stream to RGB565 pixel packer with frame/line bookkeeping.
// Frames are streamed only when capture is requested at a frame boundary; malformed lines are flagged.
module cam_pixel_pack #(
  parameter int H_ACTIVE = 480,
  parameter int V_ACTIVE = 272
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        CAPTURE,
  input  logic        CAM_VSYNC,
  input  logic        CAM_HREF,
  input  logic        CAM_VALID,
  input  logic [7:0]  CAM_DATA,
  output logic        EN,
  output logic        H_sync,
  output logic        V_sync,
  output logic [15:0] DATA_out,
  output logic        FRAME_DONE,
  output logic        LINE_ERR
);

  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);
  localparam logic [XW-1:0] X_MAX  = XW'(H_ACTIVE);
  localparam logic [YW-1:0] Y_MAX  = YW'(V_ACTIVE);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  typedef enum logic [1:0] {IDLE, ARM, ACTIVE} state_t;

  state_t        r_state;
  logic          r_phase;
  logic          r_x_ovf;
  logic [7:0]    r_hi;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;

  logic w_vsync_rise;
  logic w_href_fall;
  logic w_byte;
  logic w_active;

  // H_sync/V_sync double as the registered copies used for edge detection.
  assign w_vsync_rise = CAM_VSYNC & ~V_sync;
  assign w_href_fall  = ~CAM_HREF & H_sync;
  assign w_byte       = CAM_VALID & CAM_HREF;
  assign w_active     = (r_state == ACTIVE);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state    <= IDLE;
      r_phase    <= 1'b0;
      r_x_ovf    <= 1'b0;
      r_hi       <= 8'h00;
      r_x        <= '0;
      r_y        <= '0;
      EN         <= 1'b0;
      H_sync     <= 1'b0;
      V_sync     <= 1'b0;
      DATA_out   <= 16'h0000;
      FRAME_DONE <= 1'b0;
      LINE_ERR   <= 1'b0;
    end else begin
      H_sync     <= CAM_HREF;
      V_sync     <= CAM_VSYNC;
      EN         <= 1'b0;
      FRAME_DONE <= 1'b0;
      LINE_ERR   <= 1'b0;

      // Capture requests only take effect on a frame boundary; a running frame always completes.
      case (r_state)
        IDLE:    if (CAPTURE) r_state <= ARM;
        ARM: begin
          if (!CAPTURE)          r_state <= IDLE;
          else if (w_vsync_rise) r_state <= ACTIVE;
        end
        ACTIVE:  if (w_vsync_rise && !CAPTURE) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase

      if (w_vsync_rise) begin
        r_phase <= 1'b0;
        r_x_ovf <= 1'b0;
        r_x     <= '0;
        r_y     <= '0;
      end else if (w_byte) begin
        r_phase <= ~r_phase;
        if (!r_phase) begin
          r_hi <= CAM_DATA;
        end else if (r_x == X_MAX) begin
          r_x_ovf <= 1'b1;
        end else begin
          r_x <= r_x + 1'b1;
          if (w_active && r_y != Y_MAX) begin
            EN       <= 1'b1;
            DATA_out <= {r_hi, CAM_DATA};
          end
        end
      end else if (!CAM_HREF) begin
        r_phase <= 1'b0;
        // Overflow is tracked separately because the column count saturates at a full line.
        if (w_href_fall) begin
          r_x     <= '0;
          r_x_ovf <= 1'b0;
          if (r_x != '0 && r_y != Y_MAX) r_y <= r_y + 1'b1;
          LINE_ERR   <= w_active && (r_phase || r_x != X_MAX || r_x_ovf);
          FRAME_DONE <= w_active && r_x != '0 && r_y == Y_LAST;
        end
      end
    end
  end

endmodule

// File: tb/tb_cam_pixel_pack.sv
// Randomized scoreboard bench for cam_pixel_pack on a reduced frame geometry.
// The model works per line and per frame; a monitor matches every DUT strobe against queued expectations.
module tb_cam_pixel_pack;

  localparam int H = 16;
  localparam int V = 5;

  logic       CLK = 1'b0;
  logic       RSTn = 1'b1;
  logic       CAPTURE = 1'b0;
  logic       CAM_VSYNC = 1'b0;
  logic       CAM_HREF = 1'b0;
  logic       CAM_VALID = 1'b0;
  logic [7:0] CAM_DATA = 8'h00;

  logic        EN;
  logic        H_sync;
  logic        V_sync;
  logic [15:0] DATA_out;
  logic        FRAME_DONE;
  logic        LINE_ERR;

  typedef struct {
    logic [15:0] d;
    int          c;
  } pix_t;

  pix_t pixQ[$];
  int   errQ[$];
  int   fdQ[$];

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  bit   active = 1'b0;
  int   lineIdx = 0;
  logic hrefExp;
  logic vsyncExp;
  pix_t mp;
  int   mc;

  cam_pixel_pack #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .CAPTURE    (CAPTURE),
    .CAM_VSYNC  (CAM_VSYNC),
    .CAM_HREF   (CAM_HREF),
    .CAM_VALID  (CAM_VALID),
    .CAM_DATA   (CAM_DATA),
    .EN         (EN),
    .H_sync     (H_sync),
    .V_sync     (V_sync),
    .DATA_out   (DATA_out),
    .FRAME_DONE (FRAME_DONE),
    .LINE_ERR   (LINE_ERR)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      hrefExp  <= 1'b0;
      vsyncExp <= 1'b0;
    end else begin
      hrefExp  <= CAM_HREF;
      vsyncExp <= CAM_VSYNC;
    end
  end

  task automatic checkOutput(input string name, input bit ok, input longint act, input longint exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation, both in value and in cycle.
  always @(negedge CLK) begin
    checkOutput("H_sync", H_sync == hrefExp, H_sync, hrefExp);
    checkOutput("V_sync", V_sync == vsyncExp, V_sync, vsyncExp);
    if (EN) begin
      checkOutput("EN expected", pixQ.size() != 0, 0, 1);
      if (pixQ.size() != 0) begin
        mp = pixQ.pop_front();
        checkOutput("DATA_out", DATA_out == mp.d, DATA_out, mp.d);
        checkOutput("EN cycle", cyc == mp.c, cyc, mp.c);
      end
    end
    if (LINE_ERR) begin
      checkOutput("LINE_ERR expected", errQ.size() != 0, 0, 1);
      if (errQ.size() != 0) begin
        mc = errQ.pop_front();
        checkOutput("LINE_ERR cycle", cyc == mc, cyc, mc);
      end
    end
    if (FRAME_DONE) begin
      checkOutput("FRAME_DONE expected", fdQ.size() != 0, 0, 1);
      if (fdQ.size() != 0) begin
        mc = fdQ.pop_front();
        checkOutput("FRAME_DONE cycle", cyc == mc, cyc, mc);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      CAM_HREF  = 1'b0;
      CAM_VALID = 1'($urandom_range(0, 1));
      CAM_DATA  = 8'($urandom);
      tick();
    end
  endtask

  task automatic checkResetOutputs();
    checkOutput("reset EN", EN == 1'b0, EN, 0);
    checkOutput("reset H_sync", H_sync == 1'b0, H_sync, 0);
    checkOutput("reset V_sync", V_sync == 1'b0, V_sync, 0);
    checkOutput("reset DATA_out", DATA_out == 16'h0000, DATA_out, 0);
    checkOutput("reset FRAME_DONE", FRAME_DONE == 1'b0, FRAME_DONE, 0);
    checkOutput("reset LINE_ERR", LINE_ERR == 1'b0, LINE_ERR, 0);
  endtask

  // One line of nBytes camera bytes with random strobe gaps; expectations derive from byte/pixel counts.
  task automatic sendLine(input int nBytes, input bit pattern);
    int         i = 0;
    int         pix;
    logic [7:0] hi = 8'h00;
    logic [7:0] b;
    pix_t       p;
    while (i < nBytes) begin
      CAM_HREF = 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        CAM_VALID = 1'b0;
        CAM_DATA  = 8'($urandom);
      end else begin
        b = pattern ? ((i % 2 == 0) ? 8'hF8 : 8'h1F) : 8'($urandom);
        CAM_VALID = 1'b1;
        CAM_DATA  = b;
        if (i % 2 == 0) begin
          hi = b;
        end else if (active && (i / 2) < H && lineIdx < V) begin
          p.d = {hi, b};
          p.c = cyc + 1;
          pixQ.push_back(p);
        end
        i++;
      end
      tick();
    end
    CAM_HREF  = 1'b0;
    CAM_VALID = 1'($urandom_range(0, 1));
    CAM_DATA  = 8'($urandom);
    pix = nBytes / 2;
    if (active && (nBytes % 2 != 0 || pix != H)) errQ.push_back(cyc + 1);
    if (pix > 0 && lineIdx < V) begin
      lineIdx++;
      if (active && lineIdx == V) fdQ.push_back(cyc + 1);
    end
    tick();
    idleCycles($urandom_range(1, 4));
  endtask

  // Frame boundary; optionally a byte strobe lands on the very cycle VSYNC rises.
  task automatic sendVsync(input bit byteAtRise);
    CAM_VSYNC = 1'b1;
    active    = CAPTURE;
    lineIdx   = 0;
    if (byteAtRise) begin
      CAM_HREF  = 1'b1;
      CAM_VALID = 1'b1;
      CAM_DATA  = 8'($urandom);
    end
    tick();
    if (byteAtRise) begin
      CAM_HREF  = 1'b0;
      CAM_VALID = 1'b0;
      if (active) errQ.push_back(cyc + 1);
    end
    tick();
    tick();
    CAM_VSYNC = 1'b0;
    idleCycles(3);
  endtask

  task automatic applyStimulus();
    #2 RSTn = 1'b0;
    #1 checkResetOutputs();
    tick();
    tick();
    RSTn = 1'b1;
    idleCycles(3);

    sendVsync(1'b0);
    sendLine(2 * H, 1'b0);
    sendLine(2 * H, 1'b0);

    CAPTURE = 1'b1;
    idleCycles(3);
    sendVsync(1'b0);
    sendLine(2 * H, 1'b1);
    for (int l = 1; l < V + 2; l++) sendLine(2 * H, 1'b0);

    sendVsync(1'b1);
    sendLine(2 * H + 1, 1'b0);
    sendLine(2 * (H + 4), 1'b0);
    sendLine(2 * (H - 1), 1'b0);
    for (int l = 0; l < 3; l++) sendLine(2 * H, 1'b0);

    sendVsync(1'b0);
    sendLine(2 * H, 1'b0);
    sendLine(2 * H, 1'b0);
    CAPTURE = 1'b0;
    for (int l = 0; l < 4; l++) sendLine(2 * H, 1'b0);

    sendVsync(1'b0);
    for (int l = 0; l < 3; l++) sendLine(2 * H, 1'b0);
    CAPTURE = 1'b1;
    sendLine(2 * H, 1'b0);
    sendLine(2 * H, 1'b0);

    sendVsync(1'b0);
    for (int l = 0; l < V + 1; l++) sendLine($urandom_range(2 * H - 3, 2 * H + 3), 1'b0);

    sendVsync(1'b0);
    sendLine(2 * H, 1'b0);
    CAM_HREF  = 1'b1;
    CAM_VALID = 1'b1;
    CAM_DATA  = 8'hA5;
    tick();
    CAM_HREF  = 1'b0;
    CAM_VALID = 1'b0;
    #2 RSTn = 1'b0;
    active  = 1'b0;
    lineIdx = 0;
    #1 checkResetOutputs();
    tick();
    tick();
    RSTn = 1'b1;
    idleCycles(2);
    sendLine(2 * H, 1'b0);
    sendVsync(1'b0);
    for (int l = 0; l < V; l++) sendLine(2 * H, 1'b0);
  endtask

  initial begin
    applyStimulus();
    idleCycles(10);
    checkOutput("pixel queue drained", pixQ.size() == 0, pixQ.size(), 0);
    checkOutput("LINE_ERR queue drained", errQ.size() == 0, errQ.size(), 0);
    checkOutput("FRAME_DONE queue drained", fdQ.size() == 0, fdQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
